// File: rtl/lc_line_responder_if.sv
// L1D <-> lower-cache line interface: request channel (fill/writeback) and fill response channel.
// Handshake: a transfer happens on a rising edge where valid && ready; the source holds its payload stable while valid is high and ready is low.
interface lc_line_responder_if #(
  parameter int PADDR_BITS = 22,
  parameter int B          = 64,
  parameter int Q_DEPTH    = 4
);
  logic                      req_valid_in;
  logic                      req_ready_out;
  logic [PADDR_BITS-1:0]     req_addr_in;
  logic [8*B-1:0]            req_value_in;
  logic                      req_we_in;
  logic                      resp_valid_out;
  logic                      resp_ready_in;
  logic [PADDR_BITS-1:0]     resp_addr_out;
  logic [8*B-1:0]            resp_value_out;
  logic [$clog2(Q_DEPTH):0]  pending_out;

  modport master (
    output req_valid_in, req_addr_in, req_value_in, req_we_in, resp_ready_in,
    input  req_ready_out, resp_valid_out, resp_addr_out, resp_value_out, pending_out
  );

  modport slave (
    input  req_valid_in, req_addr_in, req_value_in, req_we_in, resp_ready_in,
    output req_ready_out, resp_valid_out, resp_addr_out, resp_value_out, pending_out
  );
endinterface

// File: rtl/lc_line_responder.sv
// Lower-cache responder: queues L1D fill/writeback requests, services each after a fixed
// latency against a direct-mapped tagged line store, and returns fill data in order.
module lc_line_responder #(
  parameter int PADDR_BITS = 22,
  parameter int B          = 64,
  parameter int LINES      = 64,
  parameter int Q_DEPTH    = 4,
  parameter int LATENCY    = 4
) (
  input  logic               clk_in,
  input  logic               rst_N_in,
  lc_line_responder_if.slave bus,
  output logic [1:0]         state_dbg
);
  localparam int OFF    = $clog2(B);
  localparam int IDX    = $clog2(LINES);
  localparam int TAG_W  = PADDR_BITS - OFF - IDX;
  localparam int LINE_W = 8 * B;
  localparam int PTR_W  = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CNT_W  = $clog2(Q_DEPTH) + 1;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t              state;
  logic [LAT_W-1:0]    lat_cnt;

  logic [PADDR_BITS-1:0] q_addr  [Q_DEPTH];
  logic [LINE_W-1:0]     q_value [Q_DEPTH];
  logic                  q_we    [Q_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_next;

  logic [PADDR_BITS-1:0] svc_addr;
  logic [LINE_W-1:0]     svc_value;
  logic                  svc_we;

  logic [TAG_W-1:0]      store_tag  [LINES];
  logic [LINE_W-1:0]     store_data [LINES];
  logic [LINES-1:0]      line_valid;

  logic                  push, pop, busy_next, store_wr, hit;
  logic [IDX-1:0]        svc_idx;
  logic [TAG_W-1:0]      svc_tag;
  logic [PADDR_BITS-1:0] line_addr;
  logic [LINE_W-1:0]     fill_pattern;

  assign state_dbg    = state;
  assign push         = bus.req_valid_in && bus.req_ready_out;
  assign pop          = (state == S_IDLE) && (count != '0);
  assign svc_idx      = svc_addr[OFF+IDX-1:OFF];
  assign svc_tag      = svc_addr[PADDR_BITS-1:OFF+IDX];
  assign line_addr    = {svc_addr[PADDR_BITS-1:OFF], {OFF{1'b0}}};
  assign fill_pattern = {(LINE_W/64){64'(line_addr)}};
  assign hit          = line_valid[svc_idx] && (store_tag[svc_idx] == svc_tag);
  assign store_wr     = (state == S_WAIT) && (lat_cnt == '0) && svc_we;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Whether a request occupies the service stage after this edge; feeds pending_out.
  always_comb begin
    busy_next = 1'b0;
    case (state)
      S_IDLE:  busy_next = pop;
      S_WAIT:  busy_next = !((lat_cnt == '0) && svc_we);
      S_RESP:  busy_next = !bus.resp_ready_in;
      default: busy_next = 1'b0;
    endcase
  end

  // Payload storage carries no reset; occupancy is tracked by count/valid bits.
  always_ff @(posedge clk_in) begin
    if (push) begin
      q_addr[wr_ptr]  <= bus.req_addr_in;
      q_value[wr_ptr] <= bus.req_value_in;
      q_we[wr_ptr]    <= bus.req_we_in;
    end
    if (pop) begin
      svc_addr  <= q_addr[rd_ptr];
      svc_value <= q_value[rd_ptr];
      svc_we    <= q_we[rd_ptr];
    end
    if (store_wr) begin
      store_tag[svc_idx]  <= svc_tag;
      store_data[svc_idx] <= svc_value;
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state              <= S_IDLE;
      lat_cnt            <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      line_valid         <= '0;
      bus.req_ready_out  <= 1'b1;
      bus.pending_out    <= '0;
      bus.resp_valid_out <= 1'b0;
      bus.resp_addr_out  <= '0;
      bus.resp_value_out <= '0;
    end else begin
      count             <= count_next;
      bus.req_ready_out <= (count_next < CNT_W'(Q_DEPTH));
      bus.pending_out   <= count_next + CNT_W'(busy_next);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case (state)
        S_IDLE: begin
          if (pop) begin
            lat_cnt <= LAT_W'(LATENCY - 1);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end else if (svc_we) begin
            line_valid[svc_idx] <= 1'b1;
            state               <= S_IDLE;
          end else begin
            bus.resp_value_out <= hit ? store_data[svc_idx] : fill_pattern;
            bus.resp_addr_out  <= line_addr;
            bus.resp_valid_out <= 1'b1;
            state              <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready_in) begin
            bus.resp_valid_out <= 1'b0;
            state              <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lc_line_responder.sv
// Directed bench for lc_line_responder: reset, cold miss latency, write/read, conflicts,
// FIFO full with response backpressure, and reset during service.
module tb_lc_line_responder;
  localparam int PA = 22;
  localparam int B  = 64;
  localparam int LW = 512;

  logic       clk_in = 1'b0;
  logic       rst_N_in;
  logic [1:0] state_dbg;
  int         errors = 0;
  int         checks = 0;

  always #5 clk_in = ~clk_in;

  lc_line_responder_if #(.PADDR_BITS(PA), .B(B), .Q_DEPTH(4)) bus ();

  lc_line_responder #(
    .PADDR_BITS(PA), .B(B), .LINES(64), .Q_DEPTH(4), .LATENCY(4)
  ) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in), .bus(bus), .state_dbg(state_dbg)
  );

  // Starts and ends just after a falling edge; returns once the request was taken.
  task automatic send(input logic [PA-1:0] a, input logic [LW-1:0] v, input logic we);
    int n;
    n = 0;
    bus.req_valid_in = 1'b1;
    bus.req_addr_in  = a;
    bus.req_value_in = v;
    bus.req_we_in    = we;
    while (!bus.req_ready_out && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (!bus.req_ready_out) begin
      errors++;
      $display("FAIL send_accept: addr %h never accepted, ready=%b required 1", a, bus.req_ready_out);
    end
    @(posedge clk_in);
    @(negedge clk_in);
    bus.req_valid_in = 1'b0;
  endtask

  // Waits (bounded) for a response and consumes it; resp_ready_in must be 1.
  task automatic get_resp(output logic [PA-1:0] a, output logic [LW-1:0] v);
    int n;
    n = 0;
    while (!bus.resp_valid_out && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    a = bus.resp_addr_out;
    v = bus.resp_value_out;
    checks++;
    if (!bus.resp_valid_out) begin
      errors++;
      $display("FAIL resp_timeout: resp_valid=%b required 1", bus.resp_valid_out);
    end else begin
      @(posedge clk_in);
      @(negedge clk_in);
    end
  endtask

  task automatic test_reset();
    rst_N_in = 1'b0;
    bus.req_valid_in = 1'b0; bus.req_addr_in = '0; bus.req_value_in = '0;
    bus.req_we_in = 1'b0; bus.resp_ready_in = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({bus.req_ready_out, bus.resp_valid_out, bus.pending_out, state_dbg} !== {1'b1, 1'b0, 3'd0, 2'd0}) begin
      errors++;
      $display("FAIL reset_ctrl: ready/valid/pending/state=%b required %b",
               {bus.req_ready_out, bus.resp_valid_out, bus.pending_out, state_dbg}, {1'b1, 1'b0, 3'd0, 2'd0});
    end
    checks++;
    if (bus.resp_addr_out !== 22'h0 || bus.resp_value_out !== 512'h0) begin
      errors++;
      $display("FAIL reset_data: resp_addr=%h required 0", bus.resp_addr_out);
    end
    rst_N_in = 1'b1;
    repeat (2) @(negedge clk_in);
    checks++;
    if (bus.req_ready_out !== 1'b1 || bus.pending_out !== 3'd0) begin
      errors++;
      $display("FAIL after_release: ready=%b pending=%0d required 1/0", bus.req_ready_out, bus.pending_out);
    end
  endtask

  task automatic test_cold_read();
    int cyc;
    send(22'h60300, '0, 1'b0);
    checks++;
    if (bus.pending_out !== 3'd1) begin
      errors++;
      $display("FAIL cold_pending_accept: pending=%0d required 1", bus.pending_out);
    end
    cyc = 0;
    while (!bus.resp_valid_out && cyc < 20) begin
      @(negedge clk_in);
      cyc++;
    end
    checks++;
    if (cyc != 5) begin
      errors++;
      $display("FAIL cold_latency: cycles=%0d required 5", cyc);
    end
    checks++;
    if (bus.resp_addr_out !== 22'h60300 || bus.resp_value_out !== {8{64'h60300}}) begin
      errors++;
      $display("FAIL cold_data: addr=%h value=%h required addr 060300", bus.resp_addr_out, bus.resp_value_out);
    end
    @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if (bus.pending_out !== 3'd0 || bus.resp_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL cold_drain: pending=%0d valid=%b required 0/0", bus.pending_out, bus.resp_valid_out);
    end
  endtask

  task automatic test_write_read();
    logic [PA-1:0] a;
    logic [LW-1:0] v;
    bit            seen;
    send(22'h2000, 512'h12345678, 1'b1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk_in);
      if (bus.resp_valid_out) seen = 1'b1;
    end
    checks++;
    if (seen || bus.pending_out !== 3'd0) begin
      errors++;
      $display("FAIL write_no_resp: resp_seen=%b pending=%0d required 0/0", seen, bus.pending_out);
    end
    send(22'h2010, '0, 1'b0);
    get_resp(a, v);
    checks++;
    if (a !== 22'h2000 || v !== 512'h12345678) begin
      errors++;
      $display("FAIL write_read: addr=%h value=%h required 002000 / 12345678", a, v);
    end
  endtask

  task automatic test_conflict();
    logic [PA-1:0] a;
    logic [LW-1:0] v;
    send(22'h4040, 512'hDEADBEEF, 1'b1);
    send(22'h14040, '0, 1'b0);
    get_resp(a, v);
    checks++;
    if (a !== 22'h14040 || v !== {8{64'h14040}}) begin
      errors++;
      $display("FAIL conflict_miss: addr=%h value=%h required 014040 fill", a, v);
    end
    send(22'h14040, 512'hAA, 1'b1);
    send(22'h4040, '0, 1'b0);
    get_resp(a, v);
    checks++;
    if (a !== 22'h4040 || v !== {8{64'h4040}}) begin
      errors++;
      $display("FAIL conflict_evict: addr=%h value=%h required 004040 fill", a, v);
    end
    send(22'h14040, '0, 1'b0);
    get_resp(a, v);
    checks++;
    if (v !== 512'hAA) begin
      errors++;
      $display("FAIL conflict_new_hit: value=%h required AA", v);
    end
  endtask

  task automatic test_fifo_full();
    logic [PA-1:0] a;
    logic [LW-1:0] v;
    logic [PA-1:0] exp_a [5];
    bit            bad;
    int            n;
    exp_a[0] = 22'h5000; exp_a[1] = 22'h7000; exp_a[2] = 22'h9000;
    exp_a[3] = 22'hF000; exp_a[4] = 22'hB000;
    bus.resp_ready_in = 1'b0;
    send(exp_a[0], '0, 1'b0);
    repeat (2) @(negedge clk_in);
    for (int i = 1; i < 5; i++) send(exp_a[i], '0, 1'b0);
    bus.req_valid_in = 1'b1;
    bus.req_addr_in  = 22'hD000;
    bus.req_we_in    = 1'b0;
    checks++;
    if (bus.req_ready_out !== 1'b0 || bus.pending_out !== 3'd5) begin
      errors++;
      $display("FAIL full_state: ready=%b pending=%0d required 0/5", bus.req_ready_out, bus.pending_out);
    end
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      if (bus.req_ready_out !== 1'b0) bad = 1'b1;
    end
    bus.req_valid_in = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL full_hold: ready rose while full, required 0");
    end
    n = 0;
    while (!bus.resp_valid_out && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (bus.resp_valid_out !== 1'b1 || bus.resp_addr_out !== 22'h5000) begin
      errors++;
      $display("FAIL stall_first: valid=%b addr=%h required 1/005000", bus.resp_valid_out, bus.resp_addr_out);
    end
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk_in);
      if (bus.resp_valid_out !== 1'b1 || bus.resp_addr_out !== 22'h5000 ||
          bus.resp_value_out !== {8{64'h5000}}) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stall_stable: response changed while stalled, addr=%h", bus.resp_addr_out);
    end
    bus.resp_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_resp(a, v);
      checks++;
      if (a !== exp_a[i] || v !== {8{64'(exp_a[i])}}) begin
        errors++;
        $display("FAIL drain_order[%0d]: addr=%h required %h", i, a, exp_a[i]);
      end
    end
    checks++;
    if (bus.pending_out !== 3'd0) begin
      errors++;
      $display("FAIL drain_pending: pending=%0d required 0", bus.pending_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [PA-1:0] a;
    logic [LW-1:0] v;
    bit            seen;
    send(22'h2000, '0, 1'b0);
    get_resp(a, v);
    checks++;
    if (v !== 512'h12345678) begin
      errors++;
      $display("FAIL pre_reset_hit: value=%h required 12345678", v);
    end
    send(22'h3000, '0, 1'b0);
    send(22'h3100, '0, 1'b0);
    send(22'h3200, '0, 1'b0);
    checks++;
    if (state_dbg !== 2'd1 || bus.pending_out !== 3'd3) begin
      errors++;
      $display("FAIL mid_setup: state=%0d pending=%0d required 1/3", state_dbg, bus.pending_out);
    end
    #2 rst_N_in = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready_out, bus.resp_valid_out, bus.pending_out, state_dbg} !== {1'b1, 1'b0, 3'd0, 2'd0}) begin
      errors++;
      $display("FAIL async_reset: ready/valid/pending/state=%b required %b",
               {bus.req_ready_out, bus.resp_valid_out, bus.pending_out, state_dbg}, {1'b1, 1'b0, 3'd0, 2'd0});
    end
    repeat (2) @(negedge clk_in);
    rst_N_in = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk_in);
      if (bus.resp_valid_out || bus.pending_out != 0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL post_reset_quiet: activity after reset, required none");
    end
    send(22'h2000, '0, 1'b0);
    get_resp(a, v);
    checks++;
    if (a !== 22'h2000 || v !== {8{64'h2000}}) begin
      errors++;
      $display("FAIL post_reset_miss: addr=%h value=%h required 002000 fill", a, v);
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_read();
    test_conflict();
    test_fifo_full();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
